// File: rtl/cfg_frame_loader_pkg.sv
// Shared constants and types for the configuration frame loader.
package cfg_frame_pkg;

   typedef logic [7:0] byte_t;

   localparam byte_t SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      PAYLOAD,
      CHECK,
      COMMIT
   } state_t;

endpackage

// File: rtl/cfg_frame_loader_if.sv
// Byte-stream valid/ready channel from the bitstream source into the loader.
interface cfg_frame_loader_if;
   import cfg_frame_pkg::*;

   byte_t in_data;
   logic  in_valid;
   logic  in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/cfg_frame_loader.sv
// Byte-serial configuration frame loader: SYNC, ADDR, payload, XOR SUM.
// A verified frame drives the shared c bus and pulses cset[addr] for one cycle.
module cfg_frame_loader
   import cfg_frame_pkg::*;
#(
   parameter int unsigned CONF_WIDTH = 20,
   parameter int unsigned NBLK       = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   cfg_frame_loader_if.slave     s_in,
   output logic [CONF_WIDTH-1:0] c,
   output logic [NBLK-1:0]       cset,
   output logic                  busy,
   output logic                  err_sum,
   output logic                  err_addr,
   input  logic                  err_clr,
   output logic [7:0]            frame_cnt
);

   localparam int unsigned NBYTES = (CONF_WIDTH + 7) / 8;
   localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   state_t                  r_state;
   byte_t                   r_addr;
   byte_t                   r_sum;
   logic [CNT_W-1:0]        r_cnt;
   logic [NBYTES*8-1:0]     r_stage;
   logic [CONF_WIDTH-1:0]   r_c;
   logic [NBLK-1:0]         r_cset;
   logic                    r_err_sum;
   logic                    r_err_addr;
   logic [7:0]              r_frame_cnt;

   logic                    w_ready;
   logic                    w_acc;
   logic                    w_addr_ok;

   assign w_ready   = (r_state != COMMIT);
   assign w_acc     = s_in.in_valid & w_ready;
   assign w_addr_ok = (32'(r_addr) < NBLK);

   assign s_in.in_ready = w_ready;
   assign busy          = (r_state != IDLE);
   assign c             = r_c;
   assign cset          = r_cset;
   assign err_sum       = r_err_sum;
   assign err_addr      = r_err_addr;
   assign frame_cnt     = r_frame_cnt;

   // Padding bits of the last payload byte only feed the checksum, never c.
   generate
      if (NBYTES * 8 > CONF_WIDTH) begin : g_pad
         logic w_unused_pad;
         assign w_unused_pad = ^r_stage[NBYTES*8-1:CONF_WIDTH];
      end
   endgenerate

   // Frame FSM with registered c/cset/error/count outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_sum       <= '0;
         r_cnt       <= '0;
         r_stage     <= '0;
         r_c         <= '0;
         r_cset      <= '0;
         r_err_sum   <= 1'b0;
         r_err_addr  <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_cset <= '0;
         // Clear first so a fault flagged in this same cycle overrides it.
         if (err_clr) begin
            r_err_sum  <= 1'b0;
            r_err_addr <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (w_acc && s_in.in_data == SYNC_BYTE) r_state <= ADDR;
            end
            ADDR: begin
               if (w_acc) begin
                  r_addr  <= s_in.in_data;
                  r_cnt   <= '0;
                  r_sum   <= '0;
                  r_state <= PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (w_acc) begin
                  for (int unsigned k = 0; k < NBYTES; k++) begin
                     if (r_cnt == CNT_W'(k)) r_stage[8*k +: 8] <= s_in.in_data;
                  end
                  r_sum <= r_sum ^ s_in.in_data;
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == CNT_W'(NBYTES - 1)) r_state <= CHECK;
               end
            end
            CHECK: begin
               if (w_acc) begin
                  if (s_in.in_data != r_sum) begin
                     r_err_sum <= 1'b1;
                     r_state   <= IDLE;
                  end else if (!w_addr_ok) begin
                     r_err_addr <= 1'b1;
                     r_state    <= IDLE;
                  end else begin
                     r_c         <= r_stage[CONF_WIDTH-1:0];
                     r_cset      <= NBLK'(1) << r_addr;
                     r_frame_cnt <= r_frame_cnt + 8'd1;
                     r_state     <= COMMIT;
                  end
               end
            end
            COMMIT: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Scoreboard bench for cfg_frame_loader: stimulus pushes expected commits,
// a negedge monitor pops and compares on every cset pulse.
module tb_cfg_frame_loader;
   import cfg_frame_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        err_clr;
   logic [19:0] c;
   logic [1:0]  cset;
   logic        busy, err_sum, err_addr;
   logic [7:0]  frame_cnt;

   int n_cmp = 0;
   int n_mis = 0;

   typedef struct packed {
      logic [1:0]  cset;
      logic [19:0] c;
      logic [7:0]  cnt;
   } exp_t;

   exp_t exp_q[$];
   bit   chk_low = 1'b0;

   cfg_frame_loader_if bus ();

   cfg_frame_loader #(.CONF_WIDTH(20), .NBLK(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_in      (bus),
      .c         (c),
      .cset      (cset),
      .busy      (busy),
      .err_sum   (err_sum),
      .err_addr  (err_addr),
      .err_clr   (err_clr),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   // Monitor: every cset pulse must match the next expected commit.
   always @(negedge clk) begin
      exp_t e;
      if (chk_low) begin
         chk_low = 1'b0;
         n_cmp++;
         if (cset !== 2'b00) begin
            n_mis++;
            $display("FAIL cset_width actual=%b required=00", cset);
         end
      end
      if (!rst && cset !== 2'b00) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_mis++;
            $display("FAIL unexpected_cset actual=%b c=%h required=no pulse", cset, c);
         end else begin
            e = exp_q.pop_front();
            if ({cset, c, frame_cnt} !== e) begin
               n_mis++;
               $display("FAIL commit actual cset=%b c=%h cnt=%0d required cset=%b c=%h cnt=%0d",
                        cset, c, frame_cnt, e.cset, e.c, e.cnt);
            end
         end
         n_cmp++;
         if (bus.in_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL commit_ready actual=%b required=0", bus.in_ready);
         end
         chk_low = 1'b1;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_mis++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Drive one byte and return after its accepting edge; waits = ready-low cycles.
   task automatic send(input byte_t b, input int unsigned gap, output int unsigned waits);
      waits = 0;
      for (int unsigned g = 0; g < gap; g++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (bus.in_ready !== 1'b1) begin
         waits++;
         if (waits > 8) begin
            n_cmp++;
            n_mis++;
            $display("FAIL accept_timeout actual=not ready required=ready byte=%h", b);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
   endtask

   task automatic send_frame(input byte_t a, input byte_t p0, input byte_t p1, input byte_t p2,
                             input byte_t s, input int unsigned gapmax, input bit clr_last,
                             output int unsigned first_wait);
      byte_t       fb [6];
      int unsigned w;
      fb = '{SYNC_BYTE, a, p0, p1, p2, s};
      first_wait = 0;
      for (int i = 0; i < 6; i++) begin
         if (i == 5 && clr_last) err_clr = 1'b1;
         send(fb[i], (gapmax > 0) ? $urandom_range(0, gapmax) : 0, w);
         if (i == 0) first_wait = w;
      end
      err_clr = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_c"},        32'(c),           32'h0);
      check({tag, "_cset"},     32'(cset),        32'h0);
      check({tag, "_ready"},    32'(bus.in_ready), 32'h1);
      check({tag, "_busy"},     32'(busy),        32'h0);
      check({tag, "_err_sum"},  32'(err_sum),     32'h0);
      check({tag, "_err_addr"}, 32'(err_addr),    32'h0);
      check({tag, "_cnt"},      32'(frame_cnt),   32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned w0, w1, w;
      rst          = 1'b1;
      err_clr      = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      idle(3);
      check_reset_outputs("reset");
      rst = 1'b0;

      // Good frame to block 1
      exp_q.push_back('{cset: 2'b10, c: 20'hF1234, cnt: 8'd1});
      send_frame(8'h01, 8'h34, 8'h12, 8'h0F, 8'h29, 0, 1'b0, w0);
      idle(2);
      check("good_cnt", 32'(frame_cnt), 32'd1);
      check("good_c", 32'(c), 32'hF1234);
      check("good_busy", 32'(busy), 32'h0);

      // Checksum fault keeps c and raises err_sum
      send_frame(8'h01, 8'h34, 8'h12, 8'h0F, 8'h28, 0, 1'b0, w);
      idle(2);
      check("sum_err_sum", 32'(err_sum), 32'h1);
      check("sum_err_addr", 32'(err_addr), 32'h0);
      check("sum_c_held", 32'(c), 32'hF1234);
      check("sum_cnt", 32'(frame_cnt), 32'd1);
      pulse_clr();
      check("clr_err_sum", 32'(err_sum), 32'h0);

      // Address fault, then a good frame to block 0
      send_frame(8'h02, 8'h34, 8'h12, 8'h0F, 8'h29, 0, 1'b0, w);
      idle(2);
      check("addr_err_addr", 32'(err_addr), 32'h1);
      check("addr_err_sum", 32'(err_sum), 32'h0);
      exp_q.push_back('{cset: 2'b01, c: 20'hF1234, cnt: 8'd2});
      send_frame(8'h00, 8'h34, 8'h12, 8'h0F, 8'h29, 0, 1'b0, w);
      idle(2);
      check("addr0_cnt", 32'(frame_cnt), 32'd2);
      pulse_clr();
      check("clr_err_addr", 32'(err_addr), 32'h0);

      // Both faults with err_clr held on the SUM edge: err_sum only, set beats clear
      send_frame(8'h05, 8'h01, 8'h02, 8'h03, 8'h07, 0, 1'b1, w);
      idle(2);
      check("both_err_sum", 32'(err_sum), 32'h1);
      check("both_err_addr", 32'(err_addr), 32'h0);
      pulse_clr();

      // Leading garbage and random stalls; top nibble of CC lies above bit 19
      send(8'h00, 1, w);
      send(8'hFF, 2, w);
      exp_q.push_back('{cset: 2'b01, c: 20'hCBBAA, cnt: 8'd3});
      send_frame(8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 3, 1'b0, w);
      idle(2);
      check("garb_c", 32'(c), 32'hCBBAA);
      check("garb_err_sum", 32'(err_sum), 32'h0);

      // Back-to-back frames at full rate: one ready bubble after the first commit
      exp_q.push_back('{cset: 2'b10, c: 20'h00001, cnt: 8'd4});
      exp_q.push_back('{cset: 2'b01, c: 20'hFFFFF, cnt: 8'd5});
      send_frame(8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 0, 1'b0, w0);
      send_frame(8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 1'b0, w1);
      idle(2);
      check("b2b_first_wait", 32'(w0), 32'd0);
      check("b2b_bubble", 32'(w1), 32'd1);
      check("b2b_cnt", 32'(frame_cnt), 32'd5);

      // Reset after the second payload byte abandons the frame
      send(SYNC_BYTE, 0, w);
      send(8'h01, 0, w);
      send(8'h11, 0, w);
      send(8'h22, 0, w);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst = 1'b1;
      idle(2);
      check_reset_outputs("midrst");
      rst = 1'b0;
      exp_q.push_back('{cset: 2'b01, c: 20'h30201, cnt: 8'd1});
      send_frame(8'h00, 8'h01, 8'h02, 8'h03, 8'h00, 0, 1'b0, w);
      idle(3);
      check("post_rst_c", 32'(c), 32'h30201);
      check("post_rst_cnt", 32'(frame_cnt), 32'd1);

      check("pending_commits", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
